// File: rtl/wb_mon_pkg.sv
// Shared types and constants for the Wishbone whitebox monitor.
package wb_mon_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    BURST = 2'd2
  } mon_state_t;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_END     = 3'b111;

  localparam int unsigned ERR_W          = 5;
  localparam int unsigned ERR_TIMEOUT    = 0;
  localparam int unsigned ERR_ABANDON    = 1;
  localparam int unsigned ERR_UNSTABLE   = 2;
  localparam int unsigned ERR_SPURIOUS   = 3;
  localparam int unsigned ERR_BURST_ADDR = 4;

endpackage

// File: rtl/wb_mon_sat_cnt.sv
// Saturating up-counter with synchronous clear; clear takes priority over increment.
module wb_mon_sat_cnt #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (inc && (cnt != {W{1'b1}})) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/wb_whitebox_monitor.sv
// Passive Wishbone slave-port monitor: beat tracking, ack latency, statistics, sticky errors.
// Define WB_MON_BURST_CHK_EN to enable the linear burst-address check (mon_err_o[4]).
module wb_whitebox_monitor
  import wb_mon_pkg::*;
#(
  parameter  int unsigned AW      = 32,
  parameter  int unsigned DW      = 32,
  parameter  int unsigned SW      = DW / 8,
  parameter  int unsigned CNT_W   = 16,
  parameter  int unsigned TIMEOUT = 256,
  localparam int unsigned LAT_W   = $clog2(TIMEOUT + 1)
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic             wb_cyc_i,
  input  logic             wb_stb_i,
  input  logic             wb_we_i,
  input  logic [AW-1:0]    wb_addr_i,
  input  logic [DW-1:0]    wb_dat_i,
  input  logic [SW-1:0]    wb_sel_i,
  input  logic [2:0]       wb_cti_i,
  input  logic [DW-1:0]    wb_dat_o,
  input  logic             wb_ack_o,
  input  logic             clr_i,
  output logic [CNT_W-1:0] mon_rd_cnt_o,
  output logic [CNT_W-1:0] mon_wr_cnt_o,
  output logic [LAT_W-1:0] mon_lat_last_o,
  output logic [LAT_W-1:0] mon_lat_max_o,
  output logic [ERR_W-1:0] mon_err_o,
  output logic             mon_txn_vld_o,
  output logic             mon_txn_we_o,
  output logic [AW-1:0]    mon_txn_addr_o,
  output logic [DW-1:0]    mon_txn_data_o
);

  mon_state_t       state;
  logic [LAT_W-1:0] lat;
  logic [AW-1:0]    cap_addr;
  logic             cap_we;
  logic [SW-1:0]    cap_sel;

  logic             req;
  logic             beat;
  logic [LAT_W-1:0] cur_lat;
  logic             timeout_hit;
  logic             burst_bad;
  logic [ERR_W-1:0] err_set;

`ifdef WB_MON_BURST_CHK_EN
  // The previous beat's address is still held in the transaction record.
  assign burst_bad = (state == BURST) && beat &&
                     (wb_addr_i != (mon_txn_addr_o + AW'(SW)));
`else
  assign burst_bad = 1'b0;
`endif

  // cur_lat is the latency the current cycle would have if it were the ack cycle.
  always_comb begin
    req         = wb_cyc_i && wb_stb_i;
    beat        = req && wb_ack_o;
    cur_lat     = lat + LAT_W'(1);
    timeout_hit = req && !wb_ack_o && (cur_lat == LAT_W'(TIMEOUT));
    err_set                 = '0;
    err_set[ERR_TIMEOUT]    = timeout_hit;
    err_set[ERR_ABANDON]    = (state == WAIT) && !req;
    err_set[ERR_UNSTABLE]   = (state == WAIT) && req && !wb_ack_o &&
                              ((wb_addr_i != cap_addr) || (wb_we_i != cap_we) ||
                               (wb_sel_i != cap_sel));
    err_set[ERR_SPURIOUS]   = wb_ack_o && !req;
    err_set[ERR_BURST_ADDR] = burst_bad;
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state          <= IDLE;
      lat            <= '0;
      cap_addr       <= '0;
      cap_we         <= 1'b0;
      cap_sel        <= '0;
      mon_lat_last_o <= '0;
      mon_lat_max_o  <= '0;
      mon_err_o      <= '0;
      mon_txn_vld_o  <= 1'b0;
      mon_txn_we_o   <= 1'b0;
      mon_txn_addr_o <= '0;
      mon_txn_data_o <= '0;
    end else begin
      mon_txn_vld_o <= beat;
      if (beat) begin
        mon_txn_we_o   <= wb_we_i;
        mon_txn_addr_o <= wb_addr_i;
        mon_txn_data_o <= wb_we_i ? wb_dat_i : wb_dat_o;
      end

      if (clr_i) begin
        mon_lat_last_o <= '0;
        mon_lat_max_o  <= '0;
        mon_err_o      <= '0;
      end else begin
        mon_err_o <= mon_err_o | err_set;
        if (beat) begin
          mon_lat_last_o <= cur_lat;
          if (cur_lat > mon_lat_max_o) mon_lat_max_o <= cur_lat;
        end
      end

      unique case (state)
        IDLE: begin
          if (beat) begin
            lat   <= '0;
            state <= (wb_cti_i == CTI_INCR) ? BURST : IDLE;
          end else if (timeout_hit) begin
            lat <= '0;
          end else if (req) begin
            state    <= WAIT;
            lat      <= cur_lat;
            cap_addr <= wb_addr_i;
            cap_we   <= wb_we_i;
            cap_sel  <= wb_sel_i;
          end
        end
        WAIT: begin
          if (!req || timeout_hit) begin
            state <= IDLE;
            lat   <= '0;
          end else if (beat) begin
            lat   <= '0;
            state <= (wb_cti_i == CTI_INCR) ? BURST : IDLE;
          end else begin
            lat <= cur_lat;
          end
        end
        BURST: begin
          if (!wb_cyc_i || timeout_hit) begin
            state <= IDLE;
            lat   <= '0;
          end else if (beat) begin
            lat   <= '0;
            state <= (wb_cti_i == CTI_END) ? IDLE : BURST;
          end else if (req) begin
            lat <= cur_lat;
          end
        end
        default: begin
          state <= IDLE;
          lat   <= '0;
        end
      endcase
    end
  end

  wb_mon_sat_cnt #(.W(CNT_W)) u_rd_cnt (
    .clk (wb_clk_i),
    .rst (wb_rst_i),
    .clr (clr_i),
    .inc (beat && !wb_we_i),
    .cnt (mon_rd_cnt_o)
  );

  wb_mon_sat_cnt #(.W(CNT_W)) u_wr_cnt (
    .clk (wb_clk_i),
    .rst (wb_rst_i),
    .clr (clr_i),
    .inc (beat && wb_we_i),
    .cnt (mon_wr_cnt_o)
  );

endmodule
